// File: rtl/regfile_pkg.sv
// Shared constants and port-slice helpers for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_NUM_RD = 2;

    // Base bit of read port k inside the packed rd_sel bus
    function automatic int addr_slice(input int port, input int addr_w);
        return port * addr_w;
    endfunction

    // Base bit of read port k inside the packed rd_data bus
    function automatic int data_slice(input int port, input int data_w);
        return port * data_w;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: resolves zero-register, bypass and written-flag, then latches.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              clr,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] mem [DEPTH],
    input  logic [DEPTH-1:0]  wv,
    input  logic [ADDR_W-1:0] sel,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] eff_s;
    logic [DATA_W-1:0] rd_data_r;

    // Effective value of the addressed entry; a clearing cycle never forwards
    always_comb begin
        eff_s = '0;
        if ((ZERO_R0 != 0) && (sel == '0)) begin
            eff_s = '0;
        end else if ((BYPASS != 0) && wr && !clr && (wr_sel == sel)) begin
            eff_s = wr_data;
        end else if (wv[sel]) begin
            eff_s = mem[sel];
        end else begin
            eff_s = '0;
        end
    end

    // Output register, updated only on an enabled read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= eff_s;
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with written flags, optional bypass and zero register.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NUM_RD  = DEF_NUM_RD,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     wr,
    input  logic [ADDR_W-1:0]        wr_sel,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     rd_vld
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  wv_r;
    logic              rd_vld_r;
    logic              wr_en_s;
    logic              rd_en_s;
    logic              zero_hit_s;

    // Write qualification: clear wins, and the zero register swallows writes
    always_comb begin
        zero_hit_s = 1'b0;
        if ((ZERO_R0 != 0) && (wr_sel == '0)) begin
            zero_hit_s = 1'b1;
        end else begin
            zero_hit_s = 1'b0;
        end
        wr_en_s = en && wr && !clr && !zero_hit_s;
        rd_en_s = en && rd;
    end

    // Storage array is intentionally not reset; wv masks stale contents
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_sel] <= wr_data;
        end
    end

    // Written flags: single-cycle clear instead of sweeping the array
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wv_r <= '0;
        end else if (en && clr) begin
            wv_r <= '0;
        end else if (wr_en_s) begin
            wv_r[wr_sel] <= 1'b1;
        end else begin
            wv_r <= wv_r;
        end
    end

    // Read-valid strobe, high for exactly the cycle after an enabled read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_r <= 1'b0;
        end else begin
            rd_vld_r <= rd_en_s;
        end
    end

    assign rd_vld = rd_vld_r;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .BYPASS  (BYPASS),
            .ZERO_R0 (ZERO_R0)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .rd_en   (rd_en_s),
            .clr     (clr),
            .wr      (wr),
            .wr_sel  (wr_sel),
            .wr_data (wr_data),
            .mem     (mem_r),
            .wv      (wv_r),
            .sel     (rd_sel[addr_slice(k, ADDR_W) +: ADDR_W]),
            .rd_data (rd_data[data_slice(k, DATA_W) +: DATA_W])
        );
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file. Successor to the fixed 16×32 two-read/one-write register file in the ALU datapath. Provides:
- configurable width, depth and number of read ports;
- registered reads with a read-valid strobe;
- selectable write-to-read bypass;
- optional hard-wired zero register;
- per-entry written flags, so a single-cycle clear does not need to sweep the array.

It sits between instruction decode (addresses, read/write strobes) and the ALU operand/result buses.

## Interface
- DATA_W, 32, width of each register
- DEPTH, 16, number of registers; power of two, 2..256
- NUM_RD, 2, number of read ports, 1..4
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read; 0 = read returns pre-write contents
- ZERO_R0, 0, 1 = register 0 reads as 0 and ignores writes
- ADDR_W (localparam), $clog2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  block enable; when 0, no state changes except reset
- clr  in  1  synchronous clear of all entries
- wr  in  1  write strobe
- wr_sel  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd  in  1  read strobe, applies to all read ports
- rd_sel  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data; port k at [k*DATA_W +: DATA_W]
- rd_vld  out  1  high for one cycle when rd_data was updated by a read

## Operation
- Storage: DEPTH×DATA_W array plus DEPTH-bit written vector wv.
  - An entry with wv[i]=0 reads as 0, whatever the array holds.
- Reset (rst=0, asynchronous):
  - wv cleared;
  - rd_data = 0;
  - rd_vld = 0.
  - Array contents are not reset.
- All of the following require en=1 at the rising edge; with en=0 all state holds and rd_vld goes to 0.
- Write, when wr=1:
  - array[wr_sel] ← wr_data;
  - wv[wr_sel] ← 1.
  - With ZERO_R0=1 and wr_sel=0, the write is discarded.
- Read, when rd=1, for each port k:
  - rd_data[k] ← effective value of entry rd_sel[k];
  - rd_vld ← 1.
  - When rd=0, rd_data holds and rd_vld ← 0.
- Effective value of entry a:
  - 0 if ZERO_R0=1 and a=0;
  - else wr_data if BYPASS=1, wr=1 and wr_sel=a;
  - else array[a] if wv[a]=1;
  - else 0.
- Clear, when clr=1:
  - wv ← 0.
  - Priority: clr > wr. A write in the same cycle is discarded.
  - A read in the same cycle returns the pre-clear contents, with no bypass.
- All read ports may address the same entry; each port resolves independently.
- No FSM. State is array, wv, rd_data and rd_vld.

## Timing
- Write latency 1: data written at edge N is visible, without bypass, to a read sampled at edge N+1.
- Read latency 1: rd/rd_sel sampled at edge N; rd_data and rd_vld valid after edge N.
- Same-cycle read and write to the same address:
  - BYPASS=1: new data after edge N;
  - BYPASS=0: old data after edge N.
- rst deassertion is synchronised externally. The first usable edge is the one after rst rises.
- Reset mid-operation: rd_data goes to 0 immediately. An in-flight write at the same edge is lost.

## Structure
- Shared package regfile_pkg holds:
  - the port-slice helper functions (addr_slice, data_slice);
  - the default DATA_W/DEPTH constants used by the ALU top.
- One sub-module, regfile_rd_port, instantiated NUM_RD times:
  - per-port address mux;
  - ZERO_R0/wv/bypass resolution;
  - the output register.
- The top level holds the array, wv, write logic and rd_vld.

## Test plan
- Reset, then read r3 on both ports without writes: rd_data = 0/0, rd_vld = 1 for one cycle.
- Write r5 = 0xDEADBEEF, next cycle read port0 = r5, port1 = r5: both 0xDEADBEEF.
- Same-cycle write r7 = 0x1234 and read r7, with r7 previously 0xAAAA: result is 0x1234 with BYPASS=1, 0xAAAA with BYPASS=0.
- Write r2 = 0x55, then clr together with write r2 = 0x66, then read r2: result is 0. A read issued in the clr cycle returns 0x55.
- ZERO_R0=1: write r0 = 0xFFFFFFFF, read r0: result is 0.
- en=0 with wr=1 and rd=1: no array change, rd_data holds, rd_vld = 0. Assert rst mid-cycle: rd_data = 0 before the next edge.
